// File: rtl/rf_read_arbiter_if.sv
// rtl/rf_read_arbiter_if.sv - request, register-file read/write and response signals of rf_read_arbiter
interface rf_read_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3:0]           rf_sel;
  logic [15:0]          rf_data;
  logic                 wr_en;
  logic [3:0]           wr_addr;
  logic [15:0]          wr_data;
  logic                 resp_valid;
  logic [15:0]          resp_data;
  logic [IDW-1:0]       resp_id;
  logic                 resp_ready;

  modport master (
    output req_valid, req_addr, rf_data, wr_en, wr_addr, wr_data, resp_ready,
    input  req_ready, rf_sel, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_addr, rf_data, wr_en, wr_addr, wr_data, resp_ready,
    output req_ready, rf_sel, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/rf_read_arbiter.sv
// rtl/rf_read_arbiter.sv - round-robin sharing of the register-file read port with a registered response
// Optional same-cycle write bypass: define RF_ARB_BYPASS_EN.
module rf_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  rf_read_arbiter_if.slave bus
);
  logic [IDW-1:0]       r_rr_ptr;
  logic                 r_resp_valid;
  logic [15:0]          r_resp_data;
  logic [IDW-1:0]       r_resp_id;

  logic                 w_can_issue;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic                 w_grant_any;
  logic [IDW:0]         w_grant_sum;
  logic [IDW-1:0]       w_grant_id;
  logic [NUM_REQ-1:0]   w_grant;
  logic [3:0]           w_sel;
  logic [IDW-1:0]       w_next_ptr;
  logic [15:0]          w_capture;

  assign w_can_issue = !r_resp_valid || bus.resp_ready;
  assign w_dbl       = {bus.req_valid, bus.req_valid};
  assign w_rot       = NUM_REQ'(w_dbl >> r_rr_ptr);

  // w_rot[k] is requester (rr_ptr + k) mod NUM_REQ, so the lowest set bit wins
  always_comb begin
    w_found     = 1'b0;
    w_grant_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found     = 1'b1;
        w_grant_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      end
    end
  end

  assign w_grant_any = w_can_issue && w_found;
  assign w_grant_id  = (w_grant_sum >= (IDW+1)'(NUM_REQ)) ?
                       IDW'(w_grant_sum - (IDW+1)'(NUM_REQ)) : IDW'(w_grant_sum);
  assign w_grant     = w_grant_any ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign w_next_ptr  = (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel = bus.req_addr[4*i +: 4];
    end
  end

`ifdef RF_ARB_BYPASS_EN
  assign w_capture = (bus.wr_en && (bus.wr_addr == w_sel)) ? bus.wr_data : bus.rf_data;
`else
  // Write port is kept on the interface but plays no part in this build
  logic w_unused_wr;
  assign w_unused_wr = &{1'b0, bus.wr_en, bus.wr_addr, bus.wr_data};
  assign w_capture   = bus.rf_data;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 16'h0000;
      r_resp_id    <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr     <= w_next_ptr;
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_capture;
      r_resp_id    <= w_grant_id;
    end else if (bus.resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.rf_sel     = w_sel;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;
endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb/tb_rf_read_arbiter.sv - randomized and directed checks of rf_read_arbiter against a scan-order model
module tb_rf_read_arbiter;
  localparam int NR = 3;
  localparam int IW = $clog2(NR);
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_read_arbiter_if #(.NUM_REQ(NR)) bus ();
  rf_read_arbiter #(.NUM_REQ(NR)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  logic [15:0] mem [16];
  logic [3:0]  ra  [NR];
  assign bus.rf_data = mem[bus.rf_sel];
  always_comb for (int i = 0; i < NR; i++) bus.req_addr[4*i +: 4] = ra[i];

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: response register contents and scan start
  bit          m_rv;
  logic [15:0] m_rd;
  int          m_rid;
  int          m_ptr;
  int          wcnt [NR];
  int          last_acc;
  logic [NR-1:0] obs_ready;
  logic [3:0]    obs_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    int g;
    logic [3:0]  sel;
    logic [15:0] cap;
    #3;
    g = -1;
    if (!m_rv || bus.resp_ready) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (g < 0 && bus.req_valid[i]) g = i;
      end
    end
    sel = (g >= 0) ? ra[g] : 4'd0;
    cap = (BYP && bus.wr_en && bus.wr_addr == sel) ? bus.wr_data : mem[sel];
    obs_ready = bus.req_ready;
    obs_sel   = bus.rf_sel;
    check("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("rf_sel", 32'(bus.rf_sel), 32'(sel));
    check("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
    check("resp_data", 32'(bus.resp_data), 32'(m_rd));
    check("resp_id", 32'(bus.resp_id), 32'(m_rid));
    for (int i = 0; i < NR; i++) if (!bus.req_valid[i]) wcnt[i] = 0;
    last_acc = -1;
    if (rst) begin
      m_rv = 1'b0; m_rd = 16'h0; m_rid = 0; m_ptr = 0;
      for (int i = 0; i < NR; i++) wcnt[i] = 0;
    end else if (g >= 0) begin
      check("fair_wait", 32'(wcnt[g] <= NR - 1), 32'd1);
      for (int i = 0; i < NR; i++) if (i != g && bus.req_valid[i]) wcnt[i]++;
      wcnt[g] = 0;
      m_rv = 1'b1; m_rd = cap; m_rid = g; m_ptr = (g + 1) % NR;
      last_acc = g;
    end else if (bus.resp_ready) begin
      m_rv = 1'b0;
    end
    @(posedge clk);
    #1;
    if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.wr_en      = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.resp_ready = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 16'h0;
    for (int i = 0; i < 16; i++) mem[i] = 16'(16'hA000 + i);
    for (int i = 0; i < NR; i++) begin ra[i] = 4'd0; wcnt[i] = 0; end
    @(posedge clk);
    #1;
    m_rv = 1'b0; m_rd = 16'h0; m_rid = 0; m_ptr = 0;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rf_sel", 32'(bus.rf_sel), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    do_reset(1);

    // single read, one-cycle latency
    mem[5] = 16'hBEEF; ra[0] = 4'd5; bus.req_valid = 3'b001; bus.resp_ready = 1'b1;
    cycle();
    check("t1_ready", 32'(obs_ready), 32'd1);
    bus.req_valid = '0;
    check("t1_valid", 32'(bus.resp_valid), 32'd1);
    check("t1_data", 32'(bus.resp_data), 32'hBEEF);
    check("t1_id", 32'(bus.resp_id), 32'd0);
    cycle();

    // rotation with everyone valid
    do_reset(1);
    ra[0] = 4'd1; ra[1] = 4'd2; ra[2] = 4'd3;
    bus.req_valid = 3'b111;
    for (int j = 0; j < 6; j++) begin
      cycle();
      check("t2_sel", 32'(obs_sel), 32'(j % 3 + 1));
      check("t2_id", 32'(bus.resp_id), 32'(j % 3));
    end

    // backpressure holds the response and blocks grants
    cycle();
    bus.resp_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      check("t3_ready", 32'(obs_ready), 32'd0);
      check("t3_data", 32'(bus.resp_data), 32'hA001);
      check("t3_id", 32'(bus.resp_id), 32'd0);
    end
    bus.resp_ready = 1'b1;
    cycle();
    check("t3_pop_grant", 32'(obs_ready), 32'b010);
    check("t3_new_id", 32'(bus.resp_id), 32'd1);

    // reset drops a pending response and rewinds the pointer
    do_reset(1);
    ra[1] = 4'd4; bus.req_valid = 3'b010;
    cycle();
    bus.req_valid = '0; bus.resp_ready = 1'b0;
    cycle();
    check("t4_pending", 32'(bus.resp_valid), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t4_rst_valid", 32'(bus.resp_valid), 32'd0);
    bus.req_valid = 3'b111; bus.resp_ready = 1'b1;
    cycle();
    check("t4_first_grant", 32'(obs_ready), 32'b001);

    // same-cycle write to the register being read
    do_reset(1);
    mem[7] = 16'h1111; ra[0] = 4'd7; bus.req_valid = 3'b001;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h2222;
    cycle();
    bus.wr_en = 1'b0; bus.req_valid = '0;
    check("t5_same_addr", 32'(bus.resp_data), BYP ? 32'h2222 : 32'h1111);
    cycle();
    mem[7] = 16'h1111; bus.req_valid = 3'b001;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd6;
    cycle();
    bus.wr_en = 1'b0; bus.req_valid = '0;
    check("t5_other_addr", 32'(bus.resp_data), 32'h1111);
    cycle();

    // scan wraps from pointer 2 back to requester 0
    do_reset(1);
    ra[1] = 4'd9; bus.req_valid = 3'b010;
    cycle();
    bus.req_valid = 3'b011;
    cycle();
    check("t6_wrap", 32'(obs_ready), 32'b001);

    // randomized traffic
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (last_acc == i || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < 60);
          ra[i] = 4'($urandom_range(0, 15));
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      bus.wr_en      = $urandom_range(0, 1) == 1;
      bus.wr_addr    = ($urandom_range(0, 1) == 1) ? ra[$urandom_range(0, NR - 1)] : 4'($urandom_range(0, 15));
      bus.wr_data    = 16'($urandom);
      rst            = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_read_arbiter.md
# rf_read_arbiter

Shares the single 16-bit register-file read port (the 16:1 select mux over the 16 × 16-bit registers) between several requesters: decode rs1, decode rs2 and the debug/monitor unit by default. Each cycle it round-robin arbitrates among pending requests and drives the mux select. It captures the selected register value into a registered response with valid/ready backpressure. It sits between the decode stage and the register file.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- IDW, $clog2(NUM_REQ), width of requester ID
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  4*NUM_REQ  flat register index; requester i uses bits [4i+3:4i]
- req_ready  out  NUM_REQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i]
- rf_sel  out  4  register index driven to the read mux
- rf_data  in  16  combinational read data returned by the mux for rf_sel
- wr_en  in  1  register-file write strobe this cycle (used only by bypass)
- wr_addr  in  4  register-file write index
- wr_data  in  16  register-file write data
- resp_valid  out  1  response holds valid data
- resp_data  out  16  read data
- resp_id  out  IDW  requester index that owns the response
- resp_ready  in  1  consumer accepts response
- Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- State: rr_ptr (IDW bits), response register {resp_valid, resp_data, resp_id}.
- can_issue = !resp_valid | resp_ready.
- Arbitration, only when can_issue: scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; the first with req_valid set wins. At most one req_ready bit is high. req_ready is all zeros when can_issue is 0 or no request is pending.
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- rf_sel = winning requester's address; 0 when no grant.
- On accept of requester g:
  - resp_data <= rf_data, or the bypass value (see Configuration)
  - resp_id <= g
  - resp_valid <= 1
  - rr_ptr <= (g+1) mod NUM_REQ
- No accept and resp_ready with resp_valid: resp_valid <= 0. resp_data and resp_id hold their last values.
- No accept and resp_valid & !resp_ready: the response register and rr_ptr hold.
- rr_ptr changes only on accept.
- Addresses are 4-bit indices 0..15; all 16 are legal. Register 0 is not special.

## Timing
- Reset values:
  - req_ready = 0 (because resp_valid = 0, it follows req_valid after reset)
  - rf_sel = 0
  - resp_valid = 0
  - resp_data = 16'h0000
  - resp_id = 0
  - rr_ptr = 0
- Latency: request accepted in cycle N gives resp_valid in cycle N+1, with data sampled from rf_data in cycle N.
- Throughput: one accept per cycle while resp_ready = 1. A response popped in cycle N can be replaced by a new accept in the same cycle N.
- Backpressure: while resp_valid & !resp_ready, no grants. Requesters keep req_valid and req_addr stable until accepted.
- Fairness: with all requesters continuously valid and resp_ready = 1, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 accepts.
- Reset mid-operation: a pending response is discarded, resp_valid = 0 next cycle, rr_ptr returns to 0.
- Write and read to the same index in the same cycle without bypass: the pre-write value is returned, per register-file read-before-write.

## Configuration
- RF_ARB_BYPASS_EN defined: if wr_en & (wr_addr == rf_sel) in the accept cycle, resp_data <= wr_data instead of rf_data.
- RF_ARB_BYPASS_EN undefined: wr_en, wr_addr and wr_data are ignored, and resp_data always comes from rf_data. The ports remain present.

## Test plan
- Reset, then req_valid = 3'b001, req_addr[3:0] = 5, rf_data = 16'hBEEF, resp_ready = 1:
  - req_ready = 3'b001 in cycle 0
  - next cycle resp_valid = 1, resp_data = 16'hBEEF, resp_id = 0
- All three valid continuously with addrs 1, 2, 3 and resp_ready = 1: grants are 0,1,2,0,1,2 on consecutive cycles, rf_sel = 1,2,3,1,2,3, and responses carry the matching ids.
- Hold resp_ready = 0 for 4 cycles after one accept:
  - req_ready = 0 throughout
  - resp_data and resp_id stable
  - on resp_ready = 1, the response pops and the next grant issues the same cycle
- Assert rst while resp_valid = 1 and rr_ptr = 2: next cycle resp_valid = 0 and rr_ptr = 0, and the first subsequent grant goes to requester 0.
- Read reg 7 (rf_data = 16'h1111) with wr_en = 1, wr_addr = 7, wr_data = 16'h2222 in the same cycle:
  - with RF_ARB_BYPASS_EN, resp_data = 16'h2222
  - without it, resp_data = 16'h1111
  - with wr_addr = 6, resp_data = 16'h1111 in both builds
- Requester 1 only valid, then requester 0 joins after rr_ptr = 2: requester 0 is granted next, because the scan wraps from 2 to 0.
